// File: rtl/demux_1x2_reg_if.sv
// Handshake bundle for the registered 1:2 demux: one producer side, two consumer slots.
interface demux_1x2_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    modport master (
        output in_valid, in_sel, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

// File: rtl/demux_1x2_reg.sv
// Registered 1:2 demultiplexer: steers each accepted word into one of two single-entry
// output slots, with wrapping per-slot delivery counters.
module demux_1x2_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    demux_1x2_reg_if.slave   bus,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    slot_state_e      state0_q, state0_d;
    slot_state_e      state1_q, state1_d;
    logic [WIDTH-1:0] data0_q, data0_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic can_acc0, can_acc1;
    logic acc0, acc1;
    logic drain0, drain1;
    logic in_ready_c;

    // A full slot can still take a word when its consumer drains it in the same cycle.
    always_comb begin
        can_acc0   = (state0_q == SLOT_EMPTY) || bus.out0_ready;
        can_acc1   = (state1_q == SLOT_EMPTY) || bus.out1_ready;
        in_ready_c = !rst && (bus.in_sel ? can_acc1 : can_acc0);
        acc0       = bus.in_valid && in_ready_c && !bus.in_sel;
        acc1       = bus.in_valid && in_ready_c &&  bus.in_sel;
        drain0     = (state0_q == SLOT_FULL) && bus.out0_ready;
        drain1     = (state1_q == SLOT_FULL) && bus.out1_ready;
    end

    always_comb begin
        state0_d = state0_q;
        state1_d = state1_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;

        if (acc0) begin
            state0_d = SLOT_FULL;
            data0_d  = bus.in_data;
        end else if (drain0) begin
            state0_d = SLOT_EMPTY;
        end

        if (acc1) begin
            state1_d = SLOT_FULL;
            data1_d  = bus.in_data;
        end else if (drain1) begin
            state1_d = SLOT_EMPTY;
        end

        if (drain0) cnt0_d = cnt0_q + CNT_W'(1);
        if (drain1) cnt1_d = cnt1_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state0_q <= SLOT_EMPTY;
            state1_q <= SLOT_EMPTY;
            data0_q  <= '0;
            data1_q  <= '0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            state0_q <= state0_d;
            state1_q <= state1_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out0_valid = (state0_q == SLOT_FULL);
    assign bus.out0_data  = data0_q;
    assign bus.out1_valid = (state1_q == SLOT_FULL);
    assign bus.out1_data  = data1_q;
    assign cnt0           = cnt0_q;
    assign cnt1           = cnt1_q;
endmodule
